range_stream_driver: RTL and testbench
======================================

# range_stream_driver

Transmit side of the go/finish sample-stream protocol consumed by the range finder. The block buffers up to DEPTH samples written by a host, then replays them as one framed stream: `go` on the first beat, `finish` on the last beat. It also computes the expected range of the frame so that benches and on-chip self-test can compare it against the receiver's `range` output. It sits between host/test logic and the range finder's `data_in`/`go`/`finish` inputs.

## Interface
- WIDTH, 8: sample width in bits.
- DEPTH, 16: buffer capacity in samples; must be ≥2 and a power of two.

- clock  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- wr_data  input  WIDTH  sample to append to the buffer.
- wr_en  input  1  append `wr_data` this cycle.
- start  input  1  request transmission of the buffered frame.
- wr_full  output  1  buffer holds DEPTH samples.
- wr_drop  output  1  sticky; a write was ignored. Cleared by an accepted `start`.
- busy  output  1  a frame is in flight (SEND or GAP state).
- done  output  1  one-cycle pulse in the GAP cycle.
- data_out  output  WIDTH  sample to the receiver.
- go  output  1  first beat of the frame.
- finish  output  1  last beat of the frame.
- exp_range  output  WIDTH  max−min of the last completed frame.

## Operation
- Buffer: an array of DEPTH×WIDTH with a write count `cnt` (0..DEPTH).
  - `wr_en` in IDLE with `cnt<DEPTH`: store `wr_data` at index `cnt`, then `cnt++`.
  - `wr_en` while busy or full: the data is not stored and `wr_drop` is set.
- `wr_full` = (cnt==DEPTH). This is combinational from a registered count.
- States: IDLE, SEND, GAP.
- IDLE → SEND on `start` with `cnt≥1`. On this transition:
  - clear `wr_drop`;
  - latch frame length `len = max(cnt,2)`;
  - beat index `idx = 0`;
  - running max = running min = buf[0].
- `start` with `cnt==0`, or `start` in SEND/GAP: ignored, with no flag.
- SEND, beat `idx`:
  - `data_out = buf[min(idx, cnt-1)]`;
  - `go` = (idx==0);
  - `finish` = (idx==len-1);
  - update running max/min with the emitted sample;
  - `idx++`.
- A single-sample frame (`cnt==1`) is sent as two beats of buf[0]. This keeps `go` and `finish` from ever being asserted together; the receiver treats that as an error.
- `go` never repeats inside a frame. Middle beats carry neither flag.
- SEND → GAP after the `finish` beat.
- GAP, exactly one cycle:
  - `go`, `finish` and `data_out` are 0;
  - `done` = 1;
  - `exp_range` ← max−min (unsigned, never negative, WIDTH bits);
  - `cnt` ← 0.
- GAP → IDLE unconditionally. The gap cycle covers the receiver's DONE→START turnaround.
- The host may begin writing the next frame in the cycle after `done`.

## Timing
- All outputs are registered.
- Reset values: `go`, `finish`, `done`, `busy`, `wr_drop`, `data_out` and `exp_range` are 0. `cnt` is 0 and the state is IDLE, so `wr_full` is 0.
- Latency: `start` sampled at edge t → `go` with buf[0] visible after edge t+1.
- Beat k of the frame is visible after edge t+1+k.
- `finish` is on beat len−1. `done` and the new `exp_range` are visible after edge t+1+len.
- `busy` is high from edge t+1 through the GAP cycle, i.e. len+1 cycles.
- Back-to-back frames: minimum period is len + 1 (gap) + 1 (`start` in IDLE) cycles, plus write cycles.
- A write and `start` in the same IDLE cycle: the write is accepted and included in the frame (`cnt` is evaluated after the write).
- Reset asserted mid-frame:
  - `go` and `finish` fall immediately (asynchronous);
  - the frame is abandoned and the buffer is emptied;
  - `exp_range` returns to 0;
  - no `done` is issued.
- Buffer contents themselves are not reset; only `cnt` defines validity.

## Test plan
- Write 5, 9, 3, 7 then pulse `start`:
  - beats are 5(go), 9, 3, 7(finish);
  - `done` after 5 cycles with `exp_range`=6;
  - a connected range finder reports 6.
- Write a single 42 then `start`: beats are 42(go), 42(finish), never both flags together, `exp_range`=0.
- Fill DEPTH=16 samples:
  - `wr_full`=1;
  - a 17th write sets `wr_drop` and leaves `cnt`=16;
  - the frame has 16 beats and `finish` appears only on beat 15;
  - `wr_drop` clears at `start`.
- Behaviour while busy and when empty:
  - `start` with `cnt`=0 does nothing;
  - a second `start` and `wr_en` during SEND are ignored, and `wr_drop`=1;
  - the frame is unaltered.
- Assert reset on beat 2 of a 4-beat frame:
  - `go`, `finish` and `busy` drop asynchronously;
  - no `done`;
  - `cnt`=0;
  - a new 2-sample frame (0, 255) then yields `exp_range`=255.
- Two frames back-to-back:
  - (10, 20) then (200, 100);
  - at least one idle cycle between the `finish` and the next `go`;
  - `exp_range` goes to 10, then 100.

Source files
------------

// File: rtl/range_stream_driver_if.sv
// Host-side and stream-side signals of the range stream driver, grouped as one bundle.
// The slave modport is the driver itself; the master modport is host/test logic.
interface range_stream_driver_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             start;
  logic             wr_full;
  logic             wr_drop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] exp_range;

  modport slave (
    input  wr_data, wr_en, start,
    output wr_full, wr_drop, busy, done, data_out, go, finish, exp_range
  );

  modport master (
    output wr_data, wr_en, start,
    input  wr_full, wr_drop, busy, done, data_out, go, finish, exp_range
  );
endinterface

// File: rtl/range_stream_driver.sv
// Buffers host samples and replays them as one go/finish framed stream, while
// tracking the frame's max-min so it can be compared with the receiver's range.
module range_stream_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic                  clock,
  input logic                  reset,
  range_stream_driver_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);
  localparam logic [CW-1:0] TwoC   = CW'(2);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_cnt, w_cnt_d, w_cnt_wr;
  logic [CW-1:0]    r_idx, w_idx_d;
  logic [CW-1:0]    r_len, w_len_d;
  logic [WIDTH-1:0] r_max, w_max_d, r_min, w_min_d;
  logic [WIDTH-1:0] r_data_out, w_data_d;
  logic [WIDTH-1:0] r_exp_range, w_range_d;
  logic             r_go, w_go_d, r_finish, w_finish_d;
  logic             r_done, w_done_d, r_busy, w_busy_d;
  logic             r_wr_drop, w_drop_d;
  logic             w_wr_ok, w_idle, w_last_beat;
  logic [CW-1:0]    w_last;
  logic [AW-1:0]    w_sel;
  logic [WIDTH-1:0] w_sample, w_first;

  logic [WIDTH-1:0] r_buf [DEPTH];

  // The cycle showing done still counts as the gap: host traffic is refused until busy falls.
  assign w_idle      = (r_state == StIdle) && !r_busy;
  assign w_last      = r_cnt - OneC;
  assign w_sel       = (r_idx < w_last) ? r_idx[AW-1:0] : w_last[AW-1:0];
  assign w_sample    = r_buf[w_sel];
  assign w_first     = (r_cnt == '0) ? bus.wr_data : r_buf[0];
  assign w_last_beat = (r_idx == r_len - OneC);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_wr   = r_cnt;
    w_wr_ok    = 1'b0;
    w_idx_d    = r_idx;
    w_len_d    = r_len;
    w_max_d    = r_max;
    w_min_d    = r_min;
    w_drop_d   = r_wr_drop;
    w_data_d   = '0;
    w_go_d     = 1'b0;
    w_finish_d = 1'b0;
    w_done_d   = 1'b0;
    w_busy_d   = 1'b0;
    w_range_d  = r_exp_range;

    if (bus.wr_en) begin
      if (w_idle && (r_cnt != DepthC)) begin
        w_wr_ok  = 1'b1;
        w_cnt_wr = r_cnt + OneC;
      end else begin
        w_drop_d = 1'b1;
      end
    end
    w_cnt_d = w_cnt_wr;

    unique case (r_state)
      StIdle: begin
        if (bus.start && w_idle && (w_cnt_wr != '0)) begin
          w_state_d = StSend;
          w_drop_d  = 1'b0;
          // A lone sample is stretched to two beats so go and finish never coincide.
          w_len_d   = (w_cnt_wr < TwoC) ? TwoC : w_cnt_wr;
          w_idx_d   = '0;
          w_max_d   = w_first;
          w_min_d   = w_first;
        end
      end
      StSend: begin
        w_busy_d   = 1'b1;
        w_data_d   = w_sample;
        w_go_d     = (r_idx == '0);
        w_finish_d = w_last_beat;
        w_max_d    = (w_sample > r_max) ? w_sample : r_max;
        w_min_d    = (w_sample < r_min) ? w_sample : r_min;
        w_idx_d    = r_idx + OneC;
        if (w_last_beat) w_state_d = StGap;
      end
      StGap: begin
        w_busy_d  = 1'b1;
        w_done_d  = 1'b1;
        w_range_d = r_max - r_min;
        w_cnt_d   = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_max       <= '0;
      r_min       <= '0;
      r_data_out  <= '0;
      r_exp_range <= '0;
      r_go        <= 1'b0;
      r_finish    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_drop   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_idx       <= w_idx_d;
      r_len       <= w_len_d;
      r_max       <= w_max_d;
      r_min       <= w_min_d;
      r_data_out  <= w_data_d;
      r_exp_range <= w_range_d;
      r_go        <= w_go_d;
      r_finish    <= w_finish_d;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
      r_wr_drop   <= w_drop_d;
    end
  end

  // Sample storage is deliberately unreset; r_cnt alone marks which entries are valid.
  always_ff @(posedge clock) begin
    if (w_wr_ok) r_buf[r_cnt[AW-1:0]] <= bus.wr_data;
  end

  assign bus.wr_full   = (r_cnt == DepthC);
  assign bus.wr_drop   = r_wr_drop;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.data_out  = r_data_out;
  assign bus.go        = r_go;
  assign bus.finish    = r_finish;
  assign bus.exp_range = r_exp_range;
endmodule

// File: tb/tb_range_stream_driver.sv
// Directed bench for range_stream_driver: stimulus pushes expected beats and ranges into
// queues, and a negedge monitor pops and compares whatever the driver presents.
module tb_range_stream_driver;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  range_stream_driver_if #(.WIDTH(8)) bus ();

  range_stream_driver #(.WIDTH(8), .DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       go;
    logic       fin;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] rng_q[$];
  logic [7:0] fr[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       prev_fin = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a beat is any busy cycle that is not the done/gap cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.busy && !bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", {24'd0, bus.data_out}, {24'd0, b.d});
          check("beat_go", {31'd0, bus.go}, {31'd0, b.go});
          check("beat_finish", {31'd0, bus.finish}, {31'd0, b.fin});
          if (bus.go) check("idle_before_go", {31'd0, prev_fin}, 32'd0);
        end
      end
      if (bus.done) begin
        if (rng_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [7:0] r;
          r = rng_q.pop_front();
          check("exp_range", {24'd0, bus.exp_range}, {24'd0, r});
        end
        check("gap_flags", {30'd0, bus.go, bus.finish}, 32'd0);
        check("gap_data", {24'd0, bus.data_out}, 32'd0);
      end
      prev_fin <= bus.finish;
    end else begin
      prev_fin <= 1'b0;
    end
  end

  task automatic write(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clock);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic add_sample(input logic [7:0] d);
    write(d);
    fr.push_back(d);
  endtask

  // Sends the samples collected in fr; rng is the hand-computed max-min of the frame.
  task automatic send_frame(input string name, input logic [7:0] rng, input bit disturb);
    int    n, len, cyc;
    beat_t b;
    n   = fr.size();
    len = (n < 2) ? 2 : n;
    for (int k = 0; k < len; k++) begin
      b.d   = fr[(k < n) ? k : n - 1];
      b.go  = (k == 0);
      b.fin = (k == len - 1);
      exp_q.push_back(b);
    end
    rng_q.push_back(rng);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    check({name, "_drop_clr"}, {31'd0, bus.wr_drop}, 32'd0);
    if (disturb) begin
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'd99;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      cyc = 1;
      check({name, "_drop_busy"}, {31'd0, bus.wr_drop}, 32'd1);
    end
    while (!bus.done && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({name, "_done_latency"}, cyc, len + 1);
    @(posedge clock);
    #1;
    check({name, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    fr.delete();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_outputs", {25'd0, bus.go, bus.finish, bus.done, bus.busy, bus.wr_drop,
                          bus.wr_full, 1'b0}, 32'd0);
    check("rst_data", {16'd0, bus.data_out, bus.exp_range}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Four-sample frame.
    add_sample(8'd5); add_sample(8'd9); add_sample(8'd3); add_sample(8'd7);
    send_frame("four", 8'd6, 1'b0);

    // Single sample is stretched to two beats.
    add_sample(8'd42);
    send_frame("single", 8'd0, 1'b0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 16; i++) begin
      check("not_full_yet", {31'd0, bus.wr_full}, 32'd0);
      add_sample(8'(i * 3 + 1));
    end
    check("full", {31'd0, bus.wr_full}, 32'd1);
    write(8'd200);
    check("overflow_drop", {31'd0, bus.wr_drop}, 32'd1);
    check("overflow_full", {31'd0, bus.wr_full}, 32'd1);
    send_frame("sixteen", 8'd45, 1'b0);

    // Start on an empty buffer does nothing.
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("empty_start_busy", {31'd0, bus.busy}, 32'd0);

    // Second start and a write during SEND are ignored.
    add_sample(8'd11); add_sample(8'd22); add_sample(8'd33);
    send_frame("disturbed", 8'd22, 1'b1);

    // Reset on beat 2 of a four-beat frame: only beats 0 and 1 are expected.
    write(8'd1); write(8'd2); write(8'd3); write(8'd4);
    exp_q.push_back('{d: 8'd1, go: 1'b1, fin: 1'b0});
    exp_q.push_back('{d: 8'd2, go: 1'b0, fin: 1'b0});
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_busy", {31'd0, bus.busy}, 32'd0);
    check("async_flags", {30'd0, bus.go, bus.finish}, 32'd0);
    check("async_range", {24'd0, bus.exp_range}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_cnt_empty", {31'd0, bus.wr_full}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("no_done_after_reset", {31'd0, bus.done}, 32'd0);
    check("reset_queue_drained", exp_q.size(), 32'd0);
    add_sample(8'd0); add_sample(8'd255);
    send_frame("after_reset", 8'd255, 1'b0);

    // Back-to-back frames.
    add_sample(8'd10); add_sample(8'd20);
    send_frame("b2b_a", 8'd10, 1'b0);
    add_sample(8'd200); add_sample(8'd100);
    send_frame("b2b_b", 8'd100, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    check("beats_left", exp_q.size(), 32'd0);
    check("ranges_left", rng_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
